sel_pipe_mux: RTL and testbench

SEL_PIPE_MUX -- requirements
Module: sel_pipe_mux

---
 rtl/sel_mux_pkg.sv | 25 ++
 rtl/pipe_skid_buf.sv | 60 ++++++
 rtl/sel_pipe_mux.sv | 144 ++++++++++++++
 tb/tb_sel_pipe_mux.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sel_mux_pkg.sv
// -----------------------------------------------------------------------------
// sel_mux_pkg
// Shared definitions for the selecting pipeline mux.
//   SEL_MUX_WIDTH_DEF  : default data width of each channel and of the output
//   SEL_MUX_NUM_IN_DEF : default number of input channels
//   skid_state_e       : occupancy encoding of the one-entry skid buffer
//   sel_in_range       : helper that reports whether a select names a real channel
// Build option: SEL_PIPE_MUX_SKID_EN adds the skid buffer that uses skid_state_e.
// -----------------------------------------------------------------------------
package sel_mux_pkg;

    localparam int SEL_MUX_WIDTH_DEF  = 32;
    localparam int SEL_MUX_NUM_IN_DEF = 4;

    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } skid_state_e;

    // True when the select value addresses one of the num_in channels
    function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_in);
        return (sel < num_in) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// One-entry holding register that catches a beat accepted while the output
// stage is stalled, so the upstream ready can come from a register.
// Only instantiated when SEL_PIPE_MUX_SKID_EN is defined.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset; empties the entry
//   push_i  : store beat_i (only honoured while empty)
//   pop_i   : release the stored beat (only honoured while full)
//   beat_i  : beat to store
//   beat_o  : stored beat
//   full_o  : entry holds a beat
// -----------------------------------------------------------------------------
module pipe_skid_buf
    import sel_mux_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [PW-1:0] beat_i,
    output logic [PW-1:0] beat_o,
    output logic          full_o
);

    skid_state_e   state_q;
    logic [PW-1:0] beat_q;

    // Occupancy state and stored payload
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SKID_EMPTY;
            beat_q  <= {PW{1'b0}};
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (push_i) begin
                        state_q <= SKID_FULL;
                        beat_q  <= beat_i;
                    end
                end
                SKID_FULL: begin
                    if (pop_i) begin
                        state_q <= SKID_EMPTY;
                    end
                end
                default: begin
                    state_q <= SKID_EMPTY;
                end
            endcase
        end
    end

    assign beat_o = beat_q;
    assign full_o = (state_q == SKID_FULL);

endmodule

// File: rtl/sel_pipe_mux.sv
// -----------------------------------------------------------------------------
// sel_pipe_mux
// Selects one of NUM_IN channels and presents it through a registered,
// valid/ready output stage (latency 1). Out-of-range selects yield zero data
// with out_err set.
// Build option: define SEL_PIPE_MUX_SKID_EN to add a one-entry skid buffer,
// which makes in_ready depend only on registered state; without it in_ready is
// !out_valid || out_ready.
// Ports:
//   clk, rst_n            : clock and synchronous active-low reset
//   in_data [NUM_IN*WIDTH]: flattened channels, channel k at [k*WIDTH +: WIDTH]
//   in_sel, in_valid      : channel select and its qualifier
//   in_ready              : input accepted when in_valid && in_ready
//   out_data/out_sel/out_err/out_valid : registered result beat
//   out_ready             : consumer takes the beat when out_valid && out_ready
// -----------------------------------------------------------------------------
module sel_pipe_mux
    import sel_mux_pkg::*;
#(
    parameter  int WIDTH  = SEL_MUX_WIDTH_DEF,
    parameter  int NUM_IN = SEL_MUX_NUM_IN_DEF,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // Beat layout: {err, sel, data}
    localparam int BEAT_W = WIDTH + SEL_W + 1;

    logic [WIDTH-1:0]  mux_data_s;
    logic              mux_err_s;
    logic [BEAT_W-1:0] in_beat_s;
    logic              accept_s;
    logic              out_load_s;
    logic              out_valid_d;
    logic [BEAT_W-1:0] out_beat_d;

    logic              out_valid_q;
    logic [WIDTH-1:0]  out_data_q;
    logic [SEL_W-1:0]  out_sel_q;
    logic              out_err_q;

    // Channel mux: OR of masked channels, so an unmatched select leaves zero
    always_comb begin
        mux_data_s = {WIDTH{1'b0}};
        for (int k = 0; k < NUM_IN; k++) begin
            mux_data_s = mux_data_s
                       | ({WIDTH{in_sel == SEL_W'(k)}} & in_data[k*WIDTH +: WIDTH]);
        end
        mux_err_s = ~sel_in_range(32'(in_sel), 32'(NUM_IN));
    end

    // Force the beat to zero while in_valid is low so an undriven bus never reaches state
    always_comb begin
        if (in_valid) begin
            in_beat_s = {mux_err_s, in_sel, mux_data_s};
        end else begin
            in_beat_s = {BEAT_W{1'b0}};
        end
    end

    assign accept_s   = in_valid & in_ready;
    // Output register may take a new beat when empty or being drained this cycle
    assign out_load_s = ~out_valid_q | out_ready;

`ifdef SEL_PIPE_MUX_SKID_EN
    logic              skid_full_s;
    logic              skid_push_s;
    logic              skid_pop_s;
    logic [BEAT_W-1:0] skid_beat_s;

    // Ready only looks at the skid register; rst_n gates it low during reset
    assign in_ready    = rst_n & ~skid_full_s;
    assign skid_push_s = accept_s & ~out_load_s;
    assign skid_pop_s  = out_load_s & skid_full_s;

    pipe_skid_buf #(
        .PW (BEAT_W)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (skid_push_s),
        .pop_i  (skid_pop_s),
        .beat_i (in_beat_s),
        .beat_o (skid_beat_s),
        .full_o (skid_full_s)
    );

    // Next output beat: the older skid entry always goes before a fresh input
    always_comb begin
        if (skid_full_s) begin
            out_valid_d = 1'b1;
            out_beat_d  = skid_beat_s;
        end else begin
            out_valid_d = accept_s;
            out_beat_d  = in_beat_s;
        end
    end
`else
    assign in_ready = rst_n & (~out_valid_q | out_ready);

    // Next output beat comes straight from the accepted input
    always_comb begin
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_beat_d  = in_beat_s;
        end else begin
            out_valid_d = 1'b0;
            out_beat_d  = {BEAT_W{1'b0}};
        end
    end
`endif

    // Output stage: holds while stalled, otherwise loads the next beat or empties
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            out_sel_q   <= {SEL_W{1'b0}};
            out_err_q   <= 1'b0;
        end else if (out_load_s) begin
            out_valid_q <= out_valid_d;
            if (out_valid_d) begin
                {out_err_q, out_sel_q, out_data_q} <= out_beat_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_sel_pipe_mux.sv
// -----------------------------------------------------------------------------
// tb_sel_pipe_mux
// Drives a 4-channel and a 3-channel instance with identical handshakes and
// compares both against a queue-based model of the pipeline occupancy.
// -----------------------------------------------------------------------------
module tb_sel_pipe_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_data;
    logic [1:0]   in_sel;

    logic        in_ready4, out_valid4, out_err4;
    logic [31:0] out_data4;
    logic [1:0]  out_sel4;
    logic        in_ready3, out_valid3, out_err3;
    logic [31:0] out_data3;
    logic [1:0]  out_sel3;

    sel_pipe_mux #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4),
        .out_sel(out_sel4), .out_err(out_err4), .out_valid(out_valid4),
        .out_ready(out_ready)
    );

    sel_pipe_mux #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[95:0]), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready3), .out_data(out_data3),
        .out_sel(out_sel3), .out_err(out_err3), .out_valid(out_valid3),
        .out_ready(out_ready)
    );

    typedef struct packed {
        logic [1:0]   sel;
        logic [127:0] bus;
    } beat_t;

    beat_t q[$];          // beats accepted but not yet delivered, oldest first
    bit    zero_out;      // output registers still hold their reset value
    int    n_cmp  = 0;
    int    n_fail = 0;
    int    n_xfer = 0;    // transfers seen on the 4-channel output

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model ready: capacity 1 that frees when draining, or 2 with registered ready
    function automatic bit model_ready(input bit rst, input bit ordy);
        if (!rst) return 1'b0;
`ifdef SEL_PIPE_MUX_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || ordy;
`endif
    endfunction

    function automatic logic [31:0] chan(input logic [127:0] bus, input int k);
        logic [127:0] sh;
        sh = bus >> (32 * k);
        return sh[31:0];
    endfunction

    // One cycle: drive after a falling edge, check, then advance the model at the rising edge
    task automatic step(input bit rst, input bit v, input logic [1:0] sel,
                        input logic [127:0] bus, input bit ordy, output bit acc);
        bit rdy;
        rst_n     = rst;
        in_valid  = v;
        out_ready = ordy;
        if (v) begin
            in_sel  = sel;
            in_data = bus;
        end else begin
            in_sel  = 2'bxx;
            in_data = {128{1'bx}};
        end
        #1;
        rdy = model_ready(rst, ordy);
        chk("in_ready4", 32'(in_ready4), 32'(rdy));
        chk("in_ready3", 32'(in_ready3), 32'(rdy));
        chk("out_valid4", 32'(out_valid4), 32'(q.size() > 0));
        chk("out_valid3", 32'(out_valid3), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_data4", out_data4, chan(q[0].bus, int'(q[0].sel)));
            chk("out_sel4", 32'(out_sel4), 32'(q[0].sel));
            chk("out_err4", 32'(out_err4), 32'd0);
            chk("out_sel3", 32'(out_sel3), 32'(q[0].sel));
            if (q[0].sel >= 2'd3) begin
                chk("out_data3", out_data3, 32'd0);
                chk("out_err3", 32'(out_err3), 32'd1);
            end else begin
                chk("out_data3", out_data3, chan(q[0].bus, int'(q[0].sel)));
                chk("out_err3", 32'(out_err3), 32'd0);
            end
        end else if (zero_out) begin
            chk("rst_data4", out_data4, 32'd0);
            chk("rst_sel4", 32'(out_sel4), 32'd0);
            chk("rst_err4", 32'(out_err4), 32'd0);
            chk("rst_data3", out_data3, 32'd0);
        end
        if (rst && out_valid4 && ordy) n_xfer++;
        acc = rst && v && rdy;
        @(posedge clk);
        if (!rst) begin
            q.delete();
            zero_out = 1'b1;
        end else begin
            if ((q.size() > 0) && ordy) void'(q.pop_front());
            if (acc) begin
                q.push_back('{sel: sel, bus: bus});
                zero_out = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [127:0] rnd_bus();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        bit           acc;
        int           k;
        int           t;
        int           x0;
        logic [127:0] bus;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_sel    = 2'd0;
        in_data   = 128'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        zero_out = 1'b1;

        // Reset state, then first cycle out of reset
        step(1'b0, 1'b0, 2'd0, 128'd0, 1'b1, acc);
        step(1'b1, 1'b0, 2'd0, 128'd0, 1'b1, acc);

        // Directed channel pick with the reference word pattern
        bus = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        step(1'b1, 1'b1, 2'd2, bus, 1'b1, acc);
        step(1'b1, 1'b0, 2'd0, bus, 1'b1, acc);
        chk("scn_ch2_data", out_data4, 32'hCCCC0002);

        // Select 3: legal on the 4-channel instance, out of range on the 3-channel one
        step(1'b1, 1'b1, 2'd3, bus, 1'b1, acc);
        step(1'b1, 1'b0, 2'd0, bus, 1'b1, acc);

        // Stall for 5 cycles with a sel=1 beat held at the output
        step(1'b1, 1'b1, 2'd1, rnd_bus(), 1'b1, acc);
        repeat (5) step(1'b1, 1'b1, 2'($urandom), rnd_bus(), 1'b0, acc);
        chk("stall_sel_held", 32'(out_sel4), 32'd1);
        repeat (3) step(1'b1, 1'b0, 2'd0, 128'd0, 1'b1, acc);

        // Stream sels 0..3 with out_ready toggling 1,0,1,0
        k = 0;
        t = 0;
        while ((k < 4) && (t < 40)) begin
            step(1'b1, 1'b1, 2'(k), rnd_bus(), (t % 2) == 0, acc);
            if (acc) k++;
            t++;
        end
        chk("stream_all_accepted", 32'(k), 32'd4);
        repeat (4) step(1'b1, 1'b0, 2'd0, 128'd0, 1'b1, acc);

        // Reset while a beat is pending: it must never come out
        step(1'b1, 1'b1, 2'd2, rnd_bus(), 1'b0, acc);
        step(1'b0, 1'b0, 2'd0, 128'd0, 1'b0, acc);
        step(1'b1, 1'b0, 2'd0, 128'd0, 1'b1, acc);
        chk("rst_discard_valid", 32'(out_valid4), 32'd0);

        // Eight back-to-back beats with out_ready held high
        x0 = n_xfer;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 2'($urandom), rnd_bus(), 1'b1, acc);
        step(1'b1, 1'b0, 2'd0, 128'd0, 1'b1, acc);
        chk("b2b_transfers", 32'(n_xfer - x0), 32'd8);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 64) != 0, ($urandom % 4) != 0, 2'($urandom), rnd_bus(),
                 ($urandom % 4) != 0, acc);
        end
        repeat (3) step(1'b1, 1'b0, 2'd0, 128'd0, 1'b1, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
